// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues memory reads and latches the instruction register.
// Optional bus timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter logic [11:0] RESET_PC       = 12'd0,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_skip,
  input  logic        pc_jump,
  input  logic [11:0] pc_target,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic [11:0] mem_rdata,
  input  logic        mem_ack,
  output logic [11:0] instruction,
  output logic [11:0] PCout,
  output logic        fetch_done,
  output logic        halted,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q;
  logic [11:0] pc_q;
  logic [11:0] instr_q;
  logic        mem_req_q;
  logic        done_q;
  logic        halted_q;
  logic        bus_err_q;
  logic [11:0] pc_idle_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] count_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Jump beats skip; the result also decides whether a same-cycle fetch halts.
  always_comb begin
    pc_idle_d = pc_q;
    if (pc_jump) begin
      pc_idle_d = pc_target;
    end else if (pc_skip) begin
      pc_idle_d = pc_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 12'd0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      count_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pc_q <= pc_idle_d;
          if (fetch_start) begin
            if (pc_idle_d == 12'hFFF) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q   <= BUSY;
              mem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              count_q   <= '0;
`endif
            end
          end
        end
        BUSY: begin
          // An ack on the final allowed cycle still completes the fetch.
          if (mem_ack) begin
            instr_q   <= mem_rdata;
            pc_q      <= pc_q + 12'd1;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (count_q == LAST_WAIT) begin
            bus_err_q <= 1'b1;
            halted_q  <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= HALT;
          end else begin
            count_q <= count_q + 1'b1;
          end
`endif
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instruction = instr_q;
  assign PCout       = pc_q;
  assign fetch_done  = done_q;
  assign halted      = halted_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of IDLE PC updates plus hand-written fetch,
// halt, timeout and reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_skip = 1'b0;
  logic        pc_jump = 1'b0;
  logic [11:0] pc_target = 12'd0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [11:0] mem_rdata = 12'd0;
  logic        mem_ack = 1'b0;
  logic [11:0] instruction;
  logic [11:0] PCout;
  logic        fetch_done;
  logic        halted;
  logic        bus_err;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic        jump;
    logic        skip;
    logic [11:0] target;
    logic [11:0] expPc;
  } vec_t;

  vec_t vecs[8];

  fetch_unit #(.RESET_PC(12'd0), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_skip(pc_skip),
    .pc_jump(pc_jump), .pc_target(pc_target), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .instruction(instruction), .PCout(PCout), .fetch_done(fetch_done),
    .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    fetch_start = 1'b0; pc_skip = 1'b0; pc_jump = 1'b0; mem_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    pc_jump = v.jump; pc_skip = v.skip; pc_target = v.target;
    step();
    pc_jump = 1'b0; pc_skip = 1'b0;
  endtask

  // Fetch at pc, acking after 'delay' wait cycles with 'data'.
  task automatic doFetch(input string name, input logic [11:0] pc, input int delay, input logic [11:0] data);
    int reqCycles = 0;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (mem_req) reqCycles++;
      checkOutput({name, " addr wait"}, 32'(mem_addr), 32'(pc));
      checkOutput({name, " done early"}, 32'(fetch_done), 0);
      step();
    end
    if (mem_req) reqCycles++;
    checkOutput({name, " addr"}, 32'(mem_addr), 32'(pc));
    mem_ack = 1'b1; mem_rdata = data;
    step();
    mem_ack = 1'b0;
    checkOutput({name, " fetch_done"}, 32'(fetch_done), 1);
    checkOutput({name, " req cycles"}, 32'(reqCycles), 32'(delay + 1));
    checkOutput({name, " instruction"}, 32'(instruction), 32'(data));
    checkOutput({name, " PCout"}, 32'(PCout), 32'(12'(pc + 12'd1)));
    checkOutput({name, " mem_req off"}, 32'(mem_req), 0);
    checkOutput({name, " bus_err"}, 32'(bus_err), 0);
    step();
    checkOutput({name, " done pulse"}, 32'(fetch_done), 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 12'd0,    12'd2};
    vecs[1] = '{1'b1, 1'b1, 12'o0400, 12'o0400};
    vecs[2] = '{1'b0, 1'b1, 12'd0,    12'o0401};
    vecs[3] = '{1'b1, 1'b0, 12'hFFF,  12'hFFF};
    vecs[4] = '{1'b0, 1'b1, 12'd0,    12'd0};
    vecs[5] = '{1'b1, 1'b0, 12'h123,  12'h123};
    vecs[6] = '{1'b0, 1'b0, 12'hABC,  12'h123};
    vecs[7] = '{1'b1, 1'b0, 12'd5,    12'd5};

    doReset();
    checkOutput("reset PCout", 32'(PCout), 0);
    checkOutput("reset instruction", 32'(instruction), 0);
    checkOutput("reset mem_req", 32'(mem_req), 0);
    checkOutput("reset fetch_done", 32'(fetch_done), 0);
    checkOutput("reset halted", 32'(halted), 0);
    checkOutput("reset bus_err", 32'(bus_err), 0);

    doFetch("first fetch", 12'd0, 0, 12'o7200);

    mem_ack = 1'b1; mem_rdata = 12'hFFF;
    step();
    mem_ack = 1'b0;
    checkOutput("idle ack instruction", 32'(instruction), 32'(12'o7200));
    checkOutput("idle ack done", 32'(fetch_done), 0);
    checkOutput("idle ack PCout", 32'(PCout), 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d PCout", i), 32'(PCout), 32'(vecs[i].expPc));
      checkOutput($sformatf("vec%0d mem_req", i), 32'(mem_req), 0);
    end

    doFetch("delayed fetch", 12'd5, 3, 12'h2A5);

    fetch_start = 1'b1;
    step();
    fetch_start = 1'b1; pc_jump = 1'b1; pc_skip = 1'b1; pc_target = 12'h0AA;
    step();
    fetch_start = 1'b0; pc_jump = 1'b0; pc_skip = 1'b0;
    checkOutput("busy ignore PCout", 32'(PCout), 6);
    checkOutput("busy ignore addr", 32'(mem_addr), 6);
    checkOutput("busy ignore req", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 12'h31C;
    step();
    mem_ack = 1'b0;
    checkOutput("busy ignore result PC", 32'(PCout), 7);
    checkOutput("busy ignore result instr", 32'(instruction), 32'(12'h31C));
    step();

`ifdef FETCH_TIMEOUT_EN
    doReset();
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checkOutput("timeout req at 15", 32'(mem_req), 1);
    checkOutput("timeout no err yet", 32'(bus_err), 0);
    step();
    checkOutput("timeout bus_err", 32'(bus_err), 1);
    checkOutput("timeout halted", 32'(halted), 1);
    checkOutput("timeout mem_req", 32'(mem_req), 0);
    doReset();
    doFetch("ack on limit", 12'd0, 14, 12'h777);
`else
    doFetch("long wait", 12'd7, 20, 12'h456);
`endif

    doReset();
    applyStimulus('{1'b1, 1'b0, 12'hFFF, 12'hFFF});
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    checkOutput("halt halted", 32'(halted), 1);
    checkOutput("halt mem_req", 32'(mem_req), 0);
    fetch_start = 1'b1; pc_skip = 1'b1;
    step();
    fetch_start = 1'b0; pc_skip = 1'b0;
    checkOutput("halt sticky", 32'(halted), 1);
    checkOutput("halt mem_req later", 32'(mem_req), 0);
    checkOutput("halt PC frozen", 32'(PCout), 32'(12'hFFF));
    mem_ack = 1'b1; mem_rdata = 12'h0F0;
    step();
    mem_ack = 1'b0;
    checkOutput("halt instr", 32'(instruction), 0);

    doReset();
    applyStimulus('{1'b1, 1'b0, 12'd7, 12'd7});
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    checkOutput("rst busy req", 32'(mem_req), 1);
    rst = 1'b0;
    #1;
    checkOutput("rst async mem_req", 32'(mem_req), 0);
    checkOutput("rst async PCout", 32'(PCout), 0);
    mem_ack = 1'b1; mem_rdata = 12'h555;
    step();
    rst = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("rst late ack instr", 32'(instruction), 0);
    checkOutput("rst late ack done", 32'(fetch_done), 0);
    checkOutput("rst late ack req", 32'(mem_req), 0);
    checkOutput("rst late ack PC", 32'(PCout), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 12'd0, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, 15, BUSY cycles without mem_ack before bus error; used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; clears the block while low.
REQ-005 fetch_start  input  1  one-cycle request from the controller to fetch the word at PC.
REQ-006 pc_skip  input  1  advance PC by one (skip instruction).
REQ-007 pc_jump  input  1  load PC from pc_target.
REQ-008 pc_target  input  12  jump/JMS destination address.
REQ-009 mem_req  output  1  memory read request, held until acknowledged.
REQ-010 mem_addr  output  12  read address; equals PC while mem_req=1.
REQ-011 mem_rdata  input  12  read data, valid in the cycle mem_ack=1.
REQ-012 mem_ack  input  1  read completion strobe.
REQ-013 instruction  output  12  instruction register contents, feeding the controller.
REQ-014 PCout  output  12  current program counter.
REQ-015 fetch_done  output  1  one-cycle pulse when instruction has been updated.
REQ-016 halted  output  1  sticky halt flag.
REQ-017 bus_err  output  1  sticky memory timeout flag.

Function
REQ-018 FSM states are IDLE, BUSY and HALT.
REQ-019 In IDLE, fetch_start with PCout==12'd4095 moves to HALT; other fetch_start values move to BUSY.
REQ-020 In BUSY, mem_req=1 and mem_addr=PCout; all other states drive mem_req=0 and mem_addr=PCout.
REQ-021 In BUSY, mem_ack=1 latches mem_rdata into instruction, sets PC to PC+1 modulo 4096, pulses fetch_done and returns to IDLE, all on the same edge.
REQ-022 An ack in the first BUSY cycle gives latency 2 cycles from fetch_start to fetch_done high; each extra wait cycle adds one.
REQ-023 mem_ack outside BUSY is ignored.
REQ-024 instruction changes only on an acknowledged fetch.
REQ-025 In IDLE, pc_jump loads pc_target and pc_skip increments PC modulo 4096, so 4095 wraps to 0.
REQ-026 pc_jump and pc_skip in the same cycle: pc_jump wins.
REQ-027 fetch_start together with pc_jump or pc_skip in IDLE: the PC update applies and the fetch uses the updated PC on the next cycle.
REQ-028 fetch_start, pc_skip and pc_jump are ignored in BUSY and HALT.
REQ-029 HALT sets halted=1 and is left only by reset.

Reset
REQ-030 rst low asynchronously sets: FSM to IDLE, PC to RESET_PC, instruction to 12'd0, mem_req 0, fetch_done 0, halted 0, bus_err 0, timeout counter 0.
REQ-031 Reset during BUSY drops mem_req immediately; an ack arriving during or after reset has no effect.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined:
- A counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
- On reaching TIMEOUT_CYCLES, bus_err goes to 1, the FSM moves to HALT (halted=1) and mem_req drops.
- An ack in the same cycle as the limit takes priority and completes the fetch normally.
REQ-033 Without FETCH_TIMEOUT_EN, BUSY waits indefinitely, no counter is built and bus_err is tied to 0.

Verification
REQ-034 Reset, then mem[0]=12'o7200 with ack in the first BUSY cycle and fetch_start -> instruction=12'o7200, PCout=1, fetch_done high exactly 2 cycles after fetch_start.
REQ-035 PC=5 with ack delayed 3 cycles -> mem_req high for 4 cycles, mem_addr=5 throughout, then PCout=6.
REQ-036 pc_jump=1, pc_skip=1, pc_target=12'o0400 in the same IDLE cycle -> PCout=12'o0400; then a skip at PC=4095 -> PCout=0.
REQ-037 pc_jump to 4095 then fetch_start -> halted=1, mem_req never asserted, later fetch_start ignored until reset.
REQ-038 With FETCH_TIMEOUT_EN, no ack for 15 BUSY cycles -> bus_err=1, halted=1, mem_req=0; with ack on cycle 15 -> normal fetch, bus_err=0.
REQ-039 rst pulled low mid-BUSY -> mem_req=0 immediately, PCout=RESET_PC, a late ack leaves instruction=0.
